// File: rtl/vga_fsw_pkg.sv
// Shared types and register map for the frame-synchronised video-slot writer.
package vga_fsw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DRAIN = 2'd2
    } fsw_state_t;

    localparam logic REG_CTRL   = 1'b0;
    localparam logic REG_STATUS = 1'b1;

    localparam int CTRL_COMMIT  = 0;
    localparam int CTRL_CLR_OVF = 1;
    localparam int CTRL_BYPASS  = 2;

    typedef struct packed {
        logic [13:0] addr;
        logic [31:0] data;
    } fsw_entry_t;

endpackage

// File: rtl/vga_fsw_fifo.sv
// Synchronous FIFO, 2^AW entries of DW bits, combinational head read.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push while full is ignored, pop while empty is ignored.
module vga_fsw_fifo #(
    parameter int AW = 5,
    parameter int DW = 46
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic [DW-1:0] pop_dat,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // count never exceeds 2^AW, so its top bit alone marks full
    assign full    = count[AW];
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vga_frame_sync_writer.sv
// Buffers video-core register writes and replays a committed batch only during vblank.
// Latency: entry popped in cycle N drives vcore_* in N+1; bypass forwards a write in one cycle.
// Backpressure: none upstream; writes to a full queue are dropped and set sticky overflow.
// Optional VGA_FSW_BYPASS_EN adds a CTRL bit that forwards writes directly when idle and empty.
module vga_frame_sync_writer
    import vga_fsw_pkg::*;
#(
    parameter int FIFO_AW = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        write,
    input  logic        read,
    input  logic [13:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    input  logic        vblank,
    output logic        vcore_cs,
    output logic        vcore_write,
    output logic [13:0] vcore_addr,
    output logic [31:0] vcore_wr_data,
    output logic        drain_done
);
    fsw_state_t       state;
    fsw_state_t       state_nxt;
    logic             vblank_q;
    logic             frame_start;
    logic             q_wr;
    logic             reg_sel;
    logic             ctrl_wr;
    logic             commit;
    logic             bypass;
    logic             byp_fwd;
    logic             push_en;
    logic             pop_en;
    logic             last_pop;
    logic             overflow;
    logic             drain_done_nxt;
    fsw_entry_t       push_ent;
    fsw_entry_t       head_ent;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FIFO_AW:0] fifo_count;

    assign frame_start = vblank & ~vblank_q;
    assign q_wr        = cs & write & ~addr[13];
    assign reg_sel     = addr[13] & (addr[12:1] == 12'd0);
    assign ctrl_wr     = cs & write & reg_sel & (addr[0] == REG_CTRL);
    assign commit      = ctrl_wr & wr_data[CTRL_COMMIT];

`ifdef VGA_FSW_BYPASS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            bypass <= 1'b0;
        end else if (ctrl_wr) begin
            bypass <= wr_data[CTRL_BYPASS];
        end
    end
    assign byp_fwd = bypass & q_wr & (state == ST_IDLE) & fifo_empty;
`else
    assign bypass  = 1'b0;
    assign byp_fwd = 1'b0;
`endif

    assign push_en       = q_wr & ~byp_fwd;
    assign push_ent.addr = addr;
    assign push_ent.data = wr_data;
    assign pop_en        = (state == ST_DRAIN) & vblank & ~fifo_empty;
    // a push landing with the final pop extends the batch instead of ending it
    assign last_pop      = pop_en & (fifo_count == (FIFO_AW+1)'(1)) & ~push_en;

    vga_fsw_fifo #(
        .AW (FIFO_AW),
        .DW ($bits(fsw_entry_t))
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push_en),
        .push_dat (push_ent),
        .pop      (pop_en),
        .pop_dat  (head_ent),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_comb begin
        state_nxt      = state;
        drain_done_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (commit & (~fifo_empty | push_en)) begin
                    state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (frame_start) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (last_pop) begin
                    state_nxt      = ST_IDLE;
                    drain_done_nxt = 1'b1;
                end else if (~vblank) begin
                    state_nxt = ST_ARMED;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            vblank_q      <= 1'b1;
            overflow      <= 1'b0;
            drain_done    <= 1'b0;
            vcore_cs      <= 1'b0;
            vcore_write   <= 1'b0;
            vcore_addr    <= '0;
            vcore_wr_data <= '0;
        end else begin
            state       <= state_nxt;
            vblank_q    <= vblank;
            drain_done  <= drain_done_nxt;
            vcore_cs    <= pop_en | byp_fwd;
            vcore_write <= pop_en | byp_fwd;
            if (push_en & fifo_full) begin
                overflow <= 1'b1;
            end else if (ctrl_wr & wr_data[CTRL_CLR_OVF]) begin
                overflow <= 1'b0;
            end
            if (pop_en) begin
                vcore_addr    <= head_ent.addr;
                vcore_wr_data <= head_ent.data;
            end else if (byp_fwd) begin
                vcore_addr    <= addr;
                vcore_wr_data <= wr_data;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (cs & read & reg_sel) begin
            if (addr[0] == REG_STATUS) begin
                rd_data[1:0]         = state;
                rd_data[2]           = overflow;
                rd_data[3]           = bypass;
                rd_data[FIFO_AW+4:4] = fifo_count;
            end else begin
                rd_data[CTRL_BYPASS] = bypass;
            end
        end
    end

endmodule

// File: doc/vga_frame_sync_writer.md
Name: vga_frame_sync_writer

Overview:
Sits between the processor video-slot bus and one video core's slot interface. It buffers register writes destined for the core and replays them only during vertical blanking, after software commits them, so that sprite, colour and other configuration changes never tear mid-frame. It owns a small write FIFO, a commit/drain FSM and a status/control register pair.

Parameters:
FIFO_AW, 5, log2 of write-queue depth (32 entries); each entry is addr[13:0] plus data[31:0], 46 bits.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cs  in  1  slot select from processor bus
write  in  1  write strobe; qualified by cs
read  in  1  read strobe; qualified by cs
addr  in  14  slot word address; addr[13]=0 queues a core write, addr[13]=1 selects a local register
wr_data  in  32  write data
rd_data  out  32  local register read data (combinational)
vblank  in  1  level, high during vertical blanking, from the frame counter
vcore_cs  out  1  select to the downstream core
vcore_write  out  1  write strobe to the downstream core
vcore_addr  out  14  downstream address
vcore_wr_data  out  32  downstream data
drain_done  out  1  one-cycle pulse when a committed batch has fully drained

Behaviour:
- Reset values: all vcore_* = 0, drain_done = 0, state = IDLE, FIFO empty, overflow = 0, bypass = 0, vblank_q = 1.
- The vblank_q = 1 reset value prevents a false edge if vblank is already high at reset release. frame_start = vblank & ~vblank_q.
- Queue write: cs & write & ~addr[13] pushes {addr, wr_data}.
  - If the FIFO is full at the start of the cycle, the write is dropped and the sticky overflow flag is set, even if a pop occurs in the same cycle.
  - Pushes are accepted in every state. They join the pending batch.
- Local registers (addr[13]=1, addr[0] selects):
  - CTRL at offset 0, write-only. Bit0 = commit, bit1 = clear overflow, bit2 = bypass (RW, see optional feature).
  - STATUS at offset 1, read-only. [1:0] state, [2] overflow, [3] bypass, [FIFO_AW+4:4] count. Other bits read 0.
  - Reading CTRL returns the bypass bit in bit2 and zeros elsewhere.
  - Undecoded addresses (addr[12:1] != 0) read 0; writes to them are ignored.
- FSM states: IDLE=0, ARMED=1, DRAIN=2.
  - IDLE to ARMED: commit with FIFO non-empty (counting a same-cycle push). Commit with an empty FIFO is ignored.
  - ARMED to DRAIN: on frame_start. A commit while ARMED or DRAIN has no effect.
  - DRAIN: pops one entry per cycle while vblank is high and the FIFO is non-empty.
  - DRAIN to IDLE: the cycle the last entry pops; drain_done is pulsed on the following cycle, aligned with the final vcore write.
  - DRAIN to ARMED: vblank falls with entries remaining. The remainder resumes at the next frame_start.
- Latency: an entry popped in cycle N appears on vcore_cs = vcore_write = 1 with its addr/data in cycle N+1, for one cycle. The outputs are registered.
- No vcore write ever issues while vblank_q is low, except in bypass.
- Reset mid-DRAIN: the FIFO is flushed, vcore_cs deasserts next cycle, and the remaining queued writes are lost.
- The count field is FIFO_AW+1 bits wide and reaches 2^FIFO_AW when full. Pointers wrap modulo the depth.

Optional Feature:
VGA_FSW_BYPASS_EN
- Defined: CTRL bit2 sets bypass.
  - In bypass, a queue write arriving with state IDLE and the FIFO empty is forwarded straight to vcore_* the next cycle and not queued.
  - Otherwise the write queues normally.
- Undefined: bit2 is ignored and reads 0; no bypass logic is synthesised.

Decomposition:
- Package vga_fsw_pkg:
  - state enum fsw_state_t
  - REG_CTRL/REG_STATUS offsets
  - CTRL bit indices
  - entry struct fsw_entry_t {addr[13:0], data[31:0]}
- Sub-module vga_fsw_fifo: synchronous FIFO parameterised on FIFO_AW and data width, with full/empty/count outputs.

Test Plan:
- Queue 3 writes (0x0010/0xA, 0x0011/0xB, 0x0012/0xC), no commit, toggle vblank -> no vcore writes; STATUS.count = 3, state = IDLE.
- Same 3 writes, commit with vblank low, then raise vblank -> vcore writes at 0x10, 0x11, 0x12 on consecutive cycles starting 2 cycles after the vblank rise; drain_done on the 0x12 cycle; state returns to IDLE.
- Queue 20 writes, commit, vblank high for 8 cycles -> 7 writes in frame 1, state = ARMED; the remaining 13 drain in the next vblank; order is preserved.
- Push 33 writes with FIFO_AW=5 -> 33rd dropped, STATUS.overflow = 1, count = 32; CTRL bit1 write clears overflow.
- Commit with empty FIFO, then raise vblank -> state stays IDLE, no vcore activity, no drain_done.
- With VGA_FSW_BYPASS_EN: set bypass, write 0x0020/0x55 in IDLE with empty FIFO -> vcore write of 0x20/0x55 the next cycle regardless of vblank; count stays 0.
